// File: rtl/packet_deframer_pkg.sv
// rtl/packet_deframer_pkg.sv - shared UART packet beat type and framing constants
package Structures;

  localparam logic [7:0] UART_SYNC = 8'h55;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic [7:0] Data;
    logic       Valid;
  } UART_PACKET;

  // A Length of zero on the wire denotes a full 256-byte payload.
  function automatic logic [8:0] payload_bytes(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/packet_deframer_byte_timeout.sv
// rtl/packet_deframer_byte_timeout.sv - inter-byte idle counter with one-cycle expiry pulse
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // Fires on the clock that would bring the count to TIMEOUT_CYCLES; a byte that cycle suppresses it.
  assign o_expired = i_enable && !i_clear && (r_count == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear || o_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/packet_deframer.sv
// rtl/packet_deframer.sv - sync hunt, header capture and payload beat framing with timeout padding
module packet_deframer
  import Structures::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output UART_PACKET opRxStream,
  output logic [7:0] opAbortCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEST,
    S_SRC,
    S_LEN,
    S_DATA,
    S_FLUSH
  } state_t;

  state_t     r_state;
  logic [8:0] r_remaining;
  logic       r_first;

  logic       w_idle_or_flush;
  logic       w_expired;
  logic       w_beat;
  logic       w_last;
  logic [7:0] w_beat_data;

  assign w_idle_or_flush = (r_state == S_IDLE) || (r_state == S_FLUSH);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (ipClk),
    .i_rst    (ipReset),
    .i_clear  (ipRxValid || w_idle_or_flush),
    .i_enable (!w_idle_or_flush),
    .o_expired(w_expired)
  );

  // A payload timeout emits its first zero pad on the expiry edge itself, so padding follows at once.
  assign w_beat      = ((r_state == S_DATA) && (ipRxValid || w_expired)) || (r_state == S_FLUSH);
  assign w_beat_data = ((r_state == S_DATA) && ipRxValid) ? ipRxData : 8'h00;
  assign w_last      = (r_remaining == 9'd1);

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_first      <= 1'b0;
      opRxStream   <= '0;
      opAbortCount <= '0;
    end else begin
      opRxStream.Valid <= 1'b0;
      opRxStream.SoP   <= 1'b0;
      opRxStream.EoP   <= 1'b0;

      if (w_expired && (opAbortCount != 8'hFF)) begin
        opAbortCount <= opAbortCount + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (ipRxValid && (ipRxData == UART_SYNC)) begin
            r_state <= S_DEST;
          end
        end
        S_DEST: begin
          if (ipRxValid) begin
            opRxStream.Destination <= ipRxData;
            r_state                <= S_SRC;
          end else if (w_expired) begin
            r_state <= S_IDLE;
          end
        end
        S_SRC: begin
          if (ipRxValid) begin
            opRxStream.Source <= ipRxData;
            r_state           <= S_LEN;
          end else if (w_expired) begin
            r_state <= S_IDLE;
          end
        end
        S_LEN: begin
          if (ipRxValid) begin
            opRxStream.Length <= ipRxData;
            r_remaining       <= payload_bytes(ipRxData);
            r_first           <= 1'b1;
            r_state           <= S_DATA;
          end else if (w_expired) begin
            r_state <= S_IDLE;
          end
        end
        S_DATA, S_FLUSH: begin
          if (w_beat) begin
            opRxStream.Valid <= 1'b1;
            opRxStream.Data  <= w_beat_data;
            opRxStream.SoP   <= r_first;
            opRxStream.EoP   <= w_last;
            r_first          <= 1'b0;
            r_remaining      <= r_remaining - 9'd1;
            if (w_last) begin
              r_state <= S_IDLE;
            end else if (!ipRxValid) begin
              r_state <= S_FLUSH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_deframer.sv
// tb/tb_packet_deframer.sv - self-checking bench for packet_deframer
module tb_packet_deframer;
  import Structures::*;

  localparam int T = 16;

  logic       ipClk = 1'b0;
  logic       ipReset = 1'b1;
  logic [7:0] ipRxData = 8'h00;
  logic       ipRxValid = 1'b0;
  UART_PACKET opRxStream;
  logic [7:0] opAbortCount;

  int checks = 0;
  int failures = 0;
  int exp_abort = 0;
  logic [7:0] pl [0:255];

  always #5 ipClk = ~ipClk;

  packet_deframer #(.TIMEOUT_CYCLES(T)) dut (
    .ipClk       (ipClk),
    .ipReset     (ipReset),
    .ipRxData    (ipRxData),
    .ipRxValid   (ipRxValid),
    .opRxStream  (opRxStream),
    .opAbortCount(opAbortCount)
  );

  // Drive one cycle of input at a falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d);
    ipRxValid = v;
    ipRxData  = d;
    @(negedge ipClk);
    ipRxValid = 1'b0;
  endtask

  task automatic chk_none(input string tag);
    checks++;
    assert (opRxStream.Valid === 1'b0 && opRxStream.SoP === 1'b0 && opRxStream.EoP === 1'b0)
    else begin
      failures++;
      $error("FAIL %s: observed valid/sop/eop=%b%b%b expected 000", tag,
             opRxStream.Valid, opRxStream.SoP, opRxStream.EoP);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic sop, input logic eop,
                          input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len);
    UART_PACKET e;
    e = '0;
    e.Source      = src;
    e.Destination = dst;
    e.Length      = len;
    e.SoP         = sop;
    e.EoP         = eop;
    e.Data        = d;
    e.Valid       = 1'b1;
    checks++;
    assert (opRxStream === e)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, opRxStream, e);
    end
  endtask

  task automatic chk_abort(input string tag);
    checks++;
    assert (opAbortCount === 8'(exp_abort))
    else begin
      failures++;
      $error("FAIL %s: observed abort=%0d expected %0d", tag, opAbortCount, exp_abort);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00);
      chk_none("idle");
    end
  endtask

  task automatic send_silent(input logic [7:0] b);
    step(1'b1, b);
    chk_none("no_beat_byte");
  endtask

  task automatic send_packet(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len,
                             input int gap);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    send_silent(UART_SYNC);
    send_silent(dst);
    send_silent(src);
    send_silent(len);
    for (int i = 0; i < n; i++) begin
      if (gap > 0) idle($urandom_range(gap, 0));
      step(1'b1, pl[i]);
      chk_beat("payload", pl[i], i == 0, i == n - 1, dst, src, len);
    end
  endtask

  initial begin
    int waited;
    logic [7:0] b;
    logic [7:0] len;

    repeat (2) @(negedge ipClk);
    checks++;
    assert (opRxStream === '0)
    else begin
      failures++;
      $error("FAIL reset_stream: observed %h expected 0", opRxStream);
    end
    chk_abort("reset_abort");
    ipReset = 1'b0;
    @(negedge ipClk);

    // Nominal packet
    pl[0] = 8'hA1; pl[1] = 8'hA2; pl[2] = 8'hA3; pl[3] = 8'hA4;
    send_packet(8'h10, 8'h01, 8'd4, 0);

    // Leading noise then single-byte payload
    send_silent(8'h00);
    send_silent(8'hFF);
    pl[0] = 8'h7E;
    send_packet(8'h20, 8'h02, 8'd1, 0);

    // Length 0 means 256 payload bytes
    for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
    send_packet(8'h10, 8'h00, 8'd0, 0);

    // Random packets with noise and short gaps; header bytes may themselves be 0x55
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < int'($urandom_range(3, 0)); k++) begin
        b = 8'($urandom);
        if (b == UART_SYNC) b = 8'h56;
        send_silent(b);
      end
      len = 8'($urandom_range(24, 1));
      for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
      send_packet(8'($urandom), 8'($urandom), len, 3);
    end
    chk_abort("no_abort_yet");

    // Header timeout
    send_silent(UART_SYNC);
    send_silent(8'h10);
    idle(T + 3);
    exp_abort++;
    chk_abort("hdr_timeout_abort");
    pl[0] = 8'h5A; pl[1] = 8'h55; pl[2] = 8'hC3;
    send_packet(8'h55, 8'h55, 8'd3, 0);

    // Payload timeout: 4 zero pads, and a sync byte during flush is dropped
    send_silent(UART_SYNC);
    send_silent(8'h10);
    send_silent(8'h01);
    send_silent(8'h06);
    step(1'b1, 8'h11);
    chk_beat("trunc_b0", 8'h11, 1'b1, 1'b0, 8'h10, 8'h01, 8'h06);
    step(1'b1, 8'h22);
    chk_beat("trunc_b1", 8'h22, 1'b0, 1'b0, 8'h10, 8'h01, 8'h06);
    waited = 0;
    do begin
      step(1'b0, 8'h00);
      waited++;
    end while (opRxStream.Valid !== 1'b1 && waited < T + 4);
    checks++;
    assert (waited >= T - 1 && waited <= T + 1)
    else begin
      failures++;
      $error("FAIL flush_start: observed %0d idle cycles expected about %0d", waited, T);
    end
    chk_beat("pad0", 8'h00, 1'b0, 1'b0, 8'h10, 8'h01, 8'h06);
    exp_abort++;
    chk_abort("payload_timeout_abort");
    step(1'b1, UART_SYNC);
    chk_beat("pad1", 8'h00, 1'b0, 1'b0, 8'h10, 8'h01, 8'h06);
    step(1'b0, 8'h00);
    chk_beat("pad2", 8'h00, 1'b0, 1'b0, 8'h10, 8'h01, 8'h06);
    step(1'b0, 8'h00);
    chk_beat("pad3", 8'h00, 1'b0, 1'b1, 8'h10, 8'h01, 8'h06);
    send_silent(8'h20);
    send_silent(8'h03);
    send_silent(8'h02);
    send_silent(8'hAA);
    send_silent(8'hBB);
    for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
    send_packet(8'h33, 8'h44, 8'd5, 2);

    // Abort counter saturation
    for (int k = 0; k < 260; k++) begin
      send_silent(UART_SYNC);
      idle(T + 1);
      if (exp_abort < 255) exp_abort++;
    end
    chk_abort("abort_saturated");

    // Asynchronous reset mid-payload
    send_silent(UART_SYNC);
    send_silent(8'h10);
    send_silent(8'h01);
    send_silent(8'h05);
    step(1'b1, 8'hB1);
    chk_beat("rst_b0", 8'hB1, 1'b1, 1'b0, 8'h10, 8'h01, 8'h05);
    step(1'b1, 8'hB2);
    chk_beat("rst_b1", 8'hB2, 1'b0, 1'b0, 8'h10, 8'h01, 8'h05);
    #2 ipReset = 1'b1;
    #1;
    exp_abort = 0;
    checks++;
    assert (opRxStream === '0)
    else begin
      failures++;
      $error("FAIL async_reset_stream: observed %h expected 0", opRxStream);
    end
    chk_abort("async_reset_abort");
    @(negedge ipClk);
    ipReset = 1'b0;
    send_silent(8'hB3);
    send_silent(8'hB4);
    send_silent(8'hB5);
    for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
    send_packet(8'h66, 8'h77, 8'd2, 0);
    chk_abort("final_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_deframer.md
# packet_deframer

Receive-side packet parser between the UART byte receiver and the packet consumers such as the sample streamer. It hunts for the sync byte, captures the Destination/Source/Length header, and presents each payload byte as a `UART_PACKET` beat with SoP/EoP framing. An inter-byte timeout recovers from truncated packets. If a packet is truncated mid-payload, the block pads it with zeros so that downstream consumers always see a terminating EoP.

## Interface
- `TIMEOUT_CYCLES`, default 20000: clocks without `ipRxValid` before an in-progress packet is abandoned (about 4 byte times at 50 MHz / 115200 baud); must be ≥ 2.
- `ipClk`, input, 1: the single clock.
- `ipReset`, input, 1: asynchronous, active-high reset.
- `ipRxData`, input, 8: byte from the UART receiver.
- `ipRxValid`, input, 1: one-cycle strobe qualifying `ipRxData`; at most one strobe per clock, with no back-pressure.
- `opRxStream`, output, `UART_PACKET`: fields Source[7:0], Destination[7:0], Length[7:0], SoP, EoP, Data[7:0], Valid.
- `opAbortCount`, output, 8: number of packets abandoned by timeout; saturates at 255.

## Operation
- Packet format on the wire: SYNC (0x55), Destination, Source, Length, then the payload bytes.
- Length rule: a Length of 1–255 means that many payload bytes. A Length of 0 means 256 payload bytes. The internal remaining-byte counter is 9 bits wide.
- State machine:
  - **Idle**: a byte equal to 0x55 moves to GetDest. Any other byte is discarded silently.
  - **GetDest**: the next byte is latched as Destination; move to GetSource.
  - **GetSource**: the next byte is latched as Source; move to GetLength.
  - **GetLength**: the next byte is latched as Length. Load remaining = (Length == 0) ? 256 : Length. Move to GetData.
  - **GetData**: each byte produces one output beat and decrements remaining. The beat where remaining reaches 0 carries EoP and returns the machine to Idle.
  - **Flush**: entered on a timeout while in GetData. Emits one beat per clock with Data = 0x00, Valid = 1, and EoP on the final beat, until remaining reaches 0. Then returns to Idle.
- Header bytes are not checked for 0x55; a value of 0x55 in the Destination, Source or Length position is taken as data.
- Output beat contents:
  - Valid = 1 for exactly one clock per beat.
  - SoP = 1 only on the first payload beat.
  - EoP = 1 only on the last beat. When the packet has a single payload byte, SoP and EoP are both 1 on that beat.
  - Destination, Source and Length are held stable from the first beat until the next header is latched.
- Timeout:
  - The counter clears on every `ipRxValid` and whenever the state is Idle or Flush.
  - It increments in GetDest, GetSource, GetLength and GetData.
  - When it reaches `TIMEOUT_CYCLES`:
    - in a header state: return to Idle with no output;
    - in GetData: enter Flush.
  - In both cases `opAbortCount` increments, saturating at 255.
- Simultaneous events: when `ipRxValid` coincides with the cycle the timeout would fire, the byte wins. The byte is processed and no timeout occurs.
- Bytes arriving during Flush are dropped. They are not counted and not parsed. In particular, a 0x55 arriving during Flush does not start a new packet.

## Timing
- Reset values: all `opRxStream` fields are 0, `opAbortCount` is 0, the state is Idle, and the counters are 0. All outputs are registered.
- Latency: a payload byte strobed at cycle N appears at the output with Valid = 1 at cycle N+1. Header bytes produce no output beat.
- Back-to-back packets: a SYNC byte strobed in the cycle immediately after the EoP byte's strobe is accepted.
- Flush rate: one beat per clock. A packet of length L truncated after k payload bytes produces L−k padding beats on consecutive clocks, starting the cycle after the timeout fires.
- Reset asserted mid-packet: all outputs clear immediately, since reset is asynchronous. No EoP is generated for the interrupted packet.

## Structure
- The `UART_PACKET` struct lives in the shared `Structures` package.
- Add constant `UART_SYNC = 8'h55` to the same package.
- The state enum is local to the module.
- One sub-module: `byte_timeout`. It holds the parameterised counter with `$clog2(TIMEOUT_CYCLES+1)` bits, has clear and enable inputs, and produces a one-cycle expiry pulse.

## Test plan
- **Nominal packet**: send 55 10 01 04 A1 A2 A3 A4 → 4 beats with Data A1..A4, Destination 0x10, Source 0x01, Length 4; SoP on A1, EoP on A4; each beat one cycle after its strobe.
- **Noise and length 1**: send 00 FF 55 20 02 01 7E → leading 00 and FF ignored; one beat with Data 0x7E and SoP = EoP = 1.
- **Length 0**: send 55 10 00 00 followed by 256 bytes → 256 beats; EoP only on the 256th beat.
- **Header timeout**: send 55 10, then idle for `TIMEOUT_CYCLES` → no output beats; `opAbortCount` = 1; a following valid packet parses normally.
- **Payload timeout**: send 55 10 01 06 11 22, then idle → beats 11 and 22, then after the timeout 4 consecutive beats of 0x00 with EoP on the last; `opAbortCount` increments.
- **Reset mid-payload**: assert `ipReset` after 2 of 5 payload bytes → outputs 0 immediately; after release, the remaining bytes are ignored until the next 0x55.
